// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter sharing one FIFO write port among
// NUM_REQ producers. An internal credit counter tracks free FIFO entries so
// writes never target a full FIFO despite the FIFO's one-cycle flag latency.
// Optional build macro FIFO_ARB_STALL_CNT_EN adds a 16-bit saturating
// stall-cycle counter output (stall_cnt).

// Per-requester data gating: passes the lane word only when that lane is
// selected, so the top can OR all lanes into one write word.
module fifo_wr_arbiter_lane #(
    parameter int DATA_W = 32
) (
    input  logic              i_sel,
    input  logic [DATA_W-1:0] i_data,
    output logic [DATA_W-1:0] o_data
);

    assign o_data = i_sel ? i_data : '0;

endmodule

module fifo_wr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 8,
    parameter int CRED_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        gnt,
    output logic                      fifo_wrt,
    output logic [DATA_W-1:0]         fifo_data,
    input  logic                      fifo_rd,
    output logic [CRED_W-1:0]         credits,
    output logic [1:0]                state
`ifdef FIFO_ARB_STALL_CNT_EN
    ,
    output logic [15:0]               stall_cnt
`endif
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        STALL = 2'd2
    } state_t;

    state_t                            r_state;
    state_t                            w_state_nxt;
    logic [CRED_W-1:0]                 r_credits;
    logic [PTR_W-1:0]                  r_rr_ptr;
    logic [NUM_REQ-1:0]                r_gnt;
    logic                              r_wrt;
    logic [DATA_W-1:0]                 r_data;

    logic                              w_any_req;
    logic                              w_rd_ok;
    logic [CRED_W:0]                   w_eff_cred;
    logic                              w_issue;
    logic                              w_found;
    logic [NUM_REQ-1:0]                w_sel_oh;
    logic [PTR_W-1:0]                  w_sel_idx;
    logic [PTR_W-1:0]                  w_ptr_nxt;
    logic [PTR_W:0]                    w_idx;
    logic [NUM_REQ-1:0][DATA_W-1:0]    w_lane_data;
    logic [DATA_W-1:0]                 w_mux_data;

    assign w_any_req = |req;

    // A read while already at DEPTH is a protocol error; drop it so the
    // counter can never exceed the real FIFO size.
    assign w_rd_ok = fifo_rd && (r_credits != CRED_W'(DEPTH));

    // A read accepted this cycle frees a slot we may fill on the same edge.
    assign w_eff_cred = {1'b0, r_credits} + (CRED_W+1)'(w_rd_ok);

    assign w_issue = w_found && (w_eff_cred != '0);

    // Rotating priority scan: first requester at or after rr_ptr, wrapping.
    always_comb begin
        w_found   = 1'b0;
        w_sel_oh  = '0;
        w_sel_idx = '0;
        w_idx     = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_rr_ptr} + (PTR_W+1)'(k);
            if (w_idx >= (PTR_W+1)'(NUM_REQ))
                w_idx = w_idx - (PTR_W+1)'(NUM_REQ);
            if (!w_found && req[w_idx[PTR_W-1:0]]) begin
                w_found                    = 1'b1;
                w_sel_idx                  = w_idx[PTR_W-1:0];
                w_sel_oh[w_idx[PTR_W-1:0]] = 1'b1;
            end
        end
    end

    // Pointer moves past the winner so it becomes lowest priority next time.
    assign w_ptr_nxt = (w_sel_idx == PTR_W'(NUM_REQ-1)) ? '0 : w_sel_idx + 1'b1;

    genvar g;
    generate
        for (g = 0; g < NUM_REQ; g++) begin : g_lane
            fifo_wr_arbiter_lane #(.DATA_W(DATA_W)) u_lane (
                .i_sel  (w_sel_oh[g]),
                .i_data (req_data[g*DATA_W +: DATA_W]),
                .o_data (w_lane_data[g])
            );
        end
    endgenerate

    // One-hot select means at most one lane is non-zero; OR them together.
    always_comb begin
        w_mux_data = '0;
        for (int k = 0; k < NUM_REQ; k++)
            w_mux_data = w_mux_data | w_lane_data[k];
    end

    // Next-state decode: no request wins, then out of credit, else granting.
    always_comb begin
        w_state_nxt = IDLE;
        if (!w_any_req)
            w_state_nxt = IDLE;
        else if (w_eff_cred == '0)
            w_state_nxt = STALL;
        else
            w_state_nxt = GRANT;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= IDLE;
        else
            r_state <= w_state_nxt;
    end

    // Grant, FIFO write port, round-robin pointer and credit bookkeeping.
    // A word registered when rst hits is dropped; its gnt was already given.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_gnt     <= '0;
            r_wrt     <= 1'b0;
            r_data    <= '0;
            r_rr_ptr  <= '0;
            r_credits <= CRED_W'(DEPTH);
        end else begin
            r_gnt     <= w_issue ? w_sel_oh : '0;
            r_wrt     <= w_issue;
            r_credits <= r_credits - CRED_W'(w_issue) + CRED_W'(w_rd_ok);
            if (w_issue) begin
                r_data   <= w_mux_data;
                r_rr_ptr <= w_ptr_nxt;
            end
        end
    end

`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0] r_stall_cnt;

    // Count cycles spent in STALL, saturating; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst)
            r_stall_cnt <= '0;
        else if (r_state == STALL && r_stall_cnt != 16'hFFFF)
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign stall_cnt = r_stall_cnt;
`endif

    assign gnt       = r_gnt;
    assign fifo_wrt  = r_wrt;
    assign fifo_data = r_data;
    assign credits   = r_credits;
    assign state     = r_state;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Testbench for fifo_wr_arbiter (NUM_REQ=4, DATA_W=32, DEPTH=8). Expected
// writes are queued as stimulus is driven and popped when fifo_wrt appears.
module tb_fifo_wr_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic [3:0]   gnt;
    logic         fifo_wrt;
    logic [31:0]  fifo_data;
    logic         fifo_rd;
    logic [3:0]   credits;
    logic [1:0]   state;
`ifdef FIFO_ARB_STALL_CNT_EN
    logic [15:0]  stall_cnt;
`endif

    typedef struct packed {
        logic [3:0]  g;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    fifo_wr_arbiter #(.NUM_REQ(4), .DATA_W(32), .DEPTH(8), .CRED_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .req_data  (req_data),
        .gnt       (gnt),
        .fifo_wrt  (fifo_wrt),
        .fifo_data (fifo_data),
        .fifo_rd   (fifo_rd),
        .credits   (credits),
        .state     (state)
`ifdef FIFO_ARB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled on the following falling edge.
    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_word(input int i, input logic [31:0] v);
        req_data[i*32 +: 32] = v;
    endtask

    function automatic exp_t mk(input logic [3:0] g, input logic [31:0] d);
        exp_t x;
        x.g = g;
        x.d = d;
        return x;
    endfunction

    task automatic test_reset();
        rst = 1'b1; req = 4'b1111; fifo_rd = 1'b0;
        for (int i = 0; i < 4; i++) set_word(i, 32'hA000_0000 + i);
        for (int k = 0; k < 2; k++) begin
            cyc();
            checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL reset_gnt: got %b want 0000", gnt); end
            checks++; if (fifo_wrt !== 1'b0) begin errors++; $display("FAIL reset_wrt: got %b want 0", fifo_wrt); end
            checks++; if (credits !== 4'd8) begin errors++; $display("FAIL reset_credits: got %0d want 8", credits); end
            checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", state); end
            checks++; if (fifo_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", fifo_data); end
        end
        rst = 1'b0;
        sb.push_back(mk(4'b0001, 32'hA000_0000));
        cyc();
        checks++;
        if (!fifo_wrt) begin errors++; $display("FAIL first_gnt: no write, gnt=%b want 0001", gnt); end
        else begin
            e = sb.pop_front();
            if (gnt !== e.g || fifo_data !== e.d) begin
                errors++; $display("FAIL first_gnt: got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data, e.g, e.d);
            end
        end
        rst = 1'b1; req = 4'b0000;
        cyc();
        rst = 1'b0;
        sb.delete();
    endtask

    task automatic test_round_robin();
        req = 4'b1111; fifo_rd = 1'b0;
        for (int i = 0; i < 4; i++) set_word(i, 32'hA000_0000 + i);
        for (int i = 0; i < 8; i++) sb.push_back(mk(4'(1 << (i % 4)), 32'hA000_0000 + (i % 4)));
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (fifo_wrt) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL rr_write: unexpected write gnt=%b data=%h at cycle %0d, want none", gnt, fifo_data, k); end
                else begin
                    e = sb.pop_front();
                    if (gnt !== e.g || fifo_data !== e.d) begin errors++; $display("FAIL rr_write: got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data, e.g, e.d); end
                end
            end
            checks++; if (credits !== 4'((k <= 8) ? 8 - k : 0)) begin errors++; $display("FAIL rr_credits: cycle %0d got %0d want %0d", k, credits, (k <= 8) ? 8 - k : 0); end
            checks++; if (state !== ((k <= 8) ? 2'd1 : 2'd2)) begin errors++; $display("FAIL rr_state: cycle %0d got %0d want %0d", k, state, (k <= 8) ? 1 : 2); end
        end
        checks++; if (fifo_data !== 32'hA000_0003) begin errors++; $display("FAIL rr_data_hold: got %h want a0000003", fifo_data); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL rr_missing: %0d writes outstanding, want 0", sb.size()); end
        sb.delete();
    endtask

    task automatic test_backpressure();
        req = 4'b0100; set_word(2, 32'hC000_0002); fifo_rd = 1'b1;
        sb.push_back(mk(4'b0100, 32'hC000_0002));
        for (int k = 1; k <= 3; k++) begin
            cyc();
            fifo_rd = 1'b0;
            if (fifo_wrt) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL bp_write: duplicate write gnt=%b data=%h, want none", gnt, fifo_data); end
                else begin
                    e = sb.pop_front();
                    if (gnt !== e.g || fifo_data !== e.d) begin errors++; $display("FAIL bp_write: got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data, e.g, e.d); end
                end
            end
            checks++; if (credits !== 4'd0) begin errors++; $display("FAIL bp_credits: cycle %0d got %0d want 0", k, credits); end
        end
        checks++; if (state !== 2'd2) begin errors++; $display("FAIL bp_state: got %0d want 2", state); end
        checks++; if (sb.size() != 0) begin errors++; $display("FAIL bp_missing: %0d writes outstanding, want 0", sb.size()); end
        req = 4'b0000;
        sb.delete();
    endtask

    task automatic test_simul_rw();
        req = 4'b0000; fifo_rd = 1'b1;
        for (int k = 1; k <= 3; k++) cyc();
        checks++; if (credits !== 4'd3) begin errors++; $display("FAIL srw_refill: got %0d want 3", credits); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL srw_idle: got %0d want 0", state); end
        req = 4'b0001;
        for (int k = 0; k < 4; k++) begin
            set_word(0, 32'hD000_0000 + k);
            sb.push_back(mk(4'b0001, 32'hD000_0000 + k));
            cyc();
            checks++;
            if (!fifo_wrt) begin errors++; $display("FAIL srw_write: cycle %0d no write, want gnt=0001", k); end
            else begin
                e = sb.pop_front();
                if (gnt !== e.g || fifo_data !== e.d) begin errors++; $display("FAIL srw_write: got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data, e.g, e.d); end
            end
            checks++; if (credits !== 4'd3) begin errors++; $display("FAIL srw_credits: cycle %0d got %0d want 3", k, credits); end
        end
        req = 4'b0000; fifo_rd = 1'b0;
        sb.delete();
    endtask

    task automatic test_wrap_skip();
        // Serve requester 2 alone so the pointer lands on 3.
        req = 4'b0100; set_word(2, 32'hE000_0002); fifo_rd = 1'b0;
        sb.push_back(mk(4'b0100, 32'hE000_0002));
        cyc();
        checks++;
        if (!fifo_wrt) begin errors++; $display("FAIL wrap_setup: no write, want gnt=0100"); end
        else begin
            e = sb.pop_front();
            if (gnt !== e.g || fifo_data !== e.d) begin errors++; $display("FAIL wrap_setup: got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data, e.g, e.d); end
        end
        checks++; if (credits !== 4'd2) begin errors++; $display("FAIL wrap_credits0: got %0d want 2", credits); end
        req = 4'b0101; fifo_rd = 1'b1;
        set_word(0, 32'hF000_0000); set_word(2, 32'hF000_0002); set_word(3, 32'hF000_0003);
        sb.push_back(mk(4'b0001, 32'hF000_0000));
        sb.push_back(mk(4'b0100, 32'hF000_0002));
        sb.push_back(mk(4'b0001, 32'hF000_0000));
        for (int k = 1; k <= 3; k++) begin
            cyc();
            checks++;
            if (!fifo_wrt) begin errors++; $display("FAIL wrap_write: cycle %0d no write", k); end
            else begin
                e = sb.pop_front();
                if (gnt !== e.g || fifo_data !== e.d) begin errors++; $display("FAIL wrap_write: got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data, e.g, e.d); end
            end
            checks++; if (credits !== 4'd2) begin errors++; $display("FAIL wrap_credits: cycle %0d got %0d want 2", k, credits); end
        end
        req = 4'b0000; fifo_rd = 1'b0;
        sb.delete();
    endtask

    task automatic test_reset_mid_burst();
        rst = 1'b1; cyc(); rst = 1'b0;
        req = 4'b1111;
        for (int i = 0; i < 4; i++) set_word(i, 32'hB000_0000 + i);
        for (int i = 0; i < 3; i++) sb.push_back(mk(4'(1 << i), 32'hB000_0000 + i));
        for (int k = 1; k <= 3; k++) begin
            cyc();
            checks++;
            if (!fifo_wrt) begin errors++; $display("FAIL mid_write: cycle %0d no write", k); end
            else begin
                e = sb.pop_front();
                if (gnt !== e.g || fifo_data !== e.d) begin errors++; $display("FAIL mid_write: got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data, e.g, e.d); end
            end
        end
        checks++; if (credits !== 4'd5) begin errors++; $display("FAIL mid_credits5: got %0d want 5", credits); end
        rst = 1'b1;
        cyc();
        checks++; if (fifo_wrt !== 1'b0) begin errors++; $display("FAIL mid_rst_wrt: got %b want 0", fifo_wrt); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mid_rst_gnt: got %b want 0000", gnt); end
        checks++; if (credits !== 4'd8) begin errors++; $display("FAIL mid_rst_credits: got %0d want 8", credits); end
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL mid_rst_state: got %0d want 0", state); end
        checks++; if (fifo_data !== 32'h0) begin errors++; $display("FAIL mid_rst_data: got %h want 0", fifo_data); end
        // Reads while already full must not push credits past DEPTH.
        rst = 1'b0; req = 4'b0000; fifo_rd = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            cyc();
            checks++; if (credits !== 4'd8) begin errors++; $display("FAIL sat_credits: cycle %0d got %0d want 8", k, credits); end
        end
        // Pointer was cleared by reset, so requester 0 wins first.
        fifo_rd = 1'b0; req = 4'b1111;
        sb.push_back(mk(4'b0001, 32'hB000_0000));
        cyc();
        req = 4'b0000;
        checks++;
        if (!fifo_wrt) begin errors++; $display("FAIL ptr_reset: no write, want gnt=0001"); end
        else begin
            e = sb.pop_front();
            if (gnt !== e.g || fifo_data !== e.d) begin errors++; $display("FAIL ptr_reset: got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data, e.g, e.d); end
        end
        checks++; if (credits !== 4'd7) begin errors++; $display("FAIL ptr_reset_credits: got %0d want 7", credits); end
        cyc();
        sb.delete();
    endtask

`ifdef FIFO_ARB_STALL_CNT_EN
    task automatic test_stall_cnt();
        rst = 1'b1; req = 4'b0000; fifo_rd = 1'b0;
        cyc();
        checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_reset: got %0d want 0", stall_cnt); end
        rst = 1'b0; req = 4'b1111;
        for (int i = 0; i < 4; i++) set_word(i, 32'h5000_0000 + i);
        for (int i = 0; i < 8; i++) sb.push_back(mk(4'(1 << (i % 4)), 32'h5000_0000 + (i % 4)));
        for (int k = 1; k <= 19; k++) begin
            cyc();
            if (fifo_wrt) begin
                checks++;
                if (sb.size() == 0) begin errors++; $display("FAIL stall_write: unexpected write at cycle %0d", k); end
                else begin
                    e = sb.pop_front();
                    if (gnt !== e.g || fifo_data !== e.d) begin errors++; $display("FAIL stall_write: got gnt=%b data=%h want gnt=%b data=%h", gnt, fifo_data, e.g, e.d); end
                end
            end
            if (k == 9) begin
                checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL stall_cnt9: got %0d want 0", stall_cnt); end
            end
        end
        checks++; if (stall_cnt !== 16'd10) begin errors++; $display("FAIL stall_cnt: got %0d want 10", stall_cnt); end
        req = 4'b0000;
        sb.delete();
    endtask
`endif

    initial begin
        rst = 1'b1; req = '0; req_data = '0; fifo_rd = 1'b0;
        test_reset();
        test_round_robin();
        test_backpressure();
        test_simul_rw();
        test_wrap_skip();
        test_reset_mid_burst();
`ifdef FIFO_ARB_STALL_CNT_EN
        test_stall_cnt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
